program_sequencer: RTL and testbench

- Fetch/sequence controller for the 8-bit BURP core; sole master of the program EEPROM address bus.
- Holds the PC, drives the EEPROM address, and latches each instruction byte into an instruction register.
- Resolves JMP/JC locally, including the operand-byte fetch, and swallows NOPs.
- Hands every other instruction to the execute unit over a valid/ready handshake.

---
 rtl/program_sequencer.sv | 162 ++++++++++++++++
 tb/tb_program_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer
// Purpose  : Fetch/sequence controller for the 8-bit BURP core. Owns the PC
//            and the program EEPROM address bus, latches each instruction
//            byte into the instruction register, resolves JMP/JC (including
//            the operand-byte fetch) and swallows NOPs locally. Every other
//            instruction is handed to the execute unit over valid/ready.
// Ports    : clk_i          - system clock, all state on rising edge
//            reset_i        - synchronous, active-high reset
//            rom_addr_o     - EEPROM address (always equals pc)
//            rom_data_i     - EEPROM data, combinational from rom_addr_o
//            carry_in_i     - carry flag from execute unit (used by JC)
//            halt_req_i     - park at the next instruction boundary
//            instr_o        - instruction to execute unit {opcode, operand}
//            instr_valid_o  - instr_o is valid
//            instr_ready_i  - execute unit accepts instr_o
//            branch_taken_o - one-cycle pulse after JMP/JC loads pc
//            halted_o       - sequencer parked in HALT
//            retired_o      - completed instructions, incl. NOP/JMP/JC
// Revision : 1.0 - initial release
// ============================================================================
module program_sequencer #(
    parameter logic [7:0] RESET_VECTOR = 8'h00,
    parameter int         COUNT_W      = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic [7:0]         rom_addr_o,
    input  logic [7:0]         rom_data_i,
    input  logic               carry_in_i,
    input  logic               halt_req_i,
    output logic [7:0]         instr_o,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic               branch_taken_o,
    output logic               halted_o,
    output logic [COUNT_W-1:0] retired_o
);

    localparam logic [3:0]         c_OP_NOP = 4'h0;
    localparam logic [3:0]         c_OP_JMP = 4'hE;
    localparam logic [3:0]         c_OP_JC  = 4'hF;
    localparam logic [COUNT_W-1:0] c_ONE    = {{(COUNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_OPERAND = 2'd1,
        S_ISSUE   = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         pc_q, pc_d;
    logic [7:0]         ir_q, ir_d;
    logic [COUNT_W-1:0] retired_q, retired_d;
    logic               valid_q, valid_d;
    logic               branch_q, branch_d;
    logic               halted_q, halted_d;

    logic [3:0]         w_fetch_op;
    logic               w_take_branch;

    assign w_fetch_op = rom_data_i[7:4];

    // In OPERAND the opcode byte already sits in ir_q; carry is only
    // looked at here, in that single cycle.
    assign w_take_branch = (ir_q[7:4] == c_OP_JMP) ||
                           ((ir_q[7:4] == c_OP_JC) && carry_in_i);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        valid_d   = valid_q;
        branch_d  = 1'b0;
        halted_d  = halted_q;

        case (state_q)
            S_FETCH: begin
                if (halt_req_i) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    ir_d = rom_data_i;
                    pc_d = pc_q + 8'd1;
                    if ((w_fetch_op == c_OP_JMP) || (w_fetch_op == c_OP_JC)) begin
                        state_d = S_OPERAND;
                    end else if (w_fetch_op == c_OP_NOP) begin
                        retired_d = retired_q + c_ONE;
                    end else begin
                        state_d = S_ISSUE;
                        valid_d = 1'b1;
                    end
                end
            end

            S_OPERAND: begin
                // rom_data_i is the target byte; pc wraps naturally at FF.
                if (w_take_branch) begin
                    pc_d     = rom_data_i;
                    branch_d = 1'b1;
                end else begin
                    pc_d = pc_q + 8'd1;
                end
                retired_d = retired_q + c_ONE;
                state_d   = S_FETCH;
            end

            S_ISSUE: begin
                // halt_req_i deliberately not looked at: halting only at
                // an instruction boundary (FETCH).
                if (valid_q && instr_ready_i) begin
                    retired_d = retired_q + c_ONE;
                    valid_d   = 1'b0;
                    state_d   = S_FETCH;
                end
            end

            S_HALT: begin
                if (!halt_req_i) begin
                    state_d  = S_FETCH;
                    halted_d = 1'b0;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_VECTOR;
            ir_q      <= 8'h00;
            retired_q <= '0;
            valid_q   <= 1'b0;
            branch_q  <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            valid_q   <= valid_d;
            branch_q  <= branch_d;
            halted_q  <= halted_d;
        end
    end

    assign rom_addr_o     = pc_q;
    assign instr_o        = ir_q;
    assign instr_valid_o  = valid_q;
    assign branch_taken_o = branch_q;
    assign halted_o       = halted_q;
    assign retired_o      = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_sequencer
// Purpose  : Self-checking bench for program_sequencer. Directed scenarios
//            cover reset, issue timing, stalls, JMP/JC, NOP streams with pc
//            wrap, halt and reset mid-instruction. Randomised rounds run a
//            random program against an instruction-level interpreter of the
//            BURP fetch rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        carry_in;
    logic        halt_req;
    logic [7:0]  instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic        halted;
    logic [15:0] retired;

    logic [7:0]  rom [256];

    int checks = 0;
    int errors = 0;

    // Interpreter state for the randomised rounds
    logic [7:0]  m_pc;
    logic        m_carry;
    int          m_retired;
    int          m_br;

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    program_sequencer #(
        .RESET_VECTOR (8'h00),
        .COUNT_W      (16)
    ) u_dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .rom_addr_o     (rom_addr),
        .rom_data_i     (rom_data),
        .carry_in_i     (carry_in),
        .halt_req_i     (halt_req),
        .instr_o        (instr),
        .instr_valid_o  (instr_valid),
        .instr_ready_i  (instr_ready),
        .branch_taken_o (branch_taken),
        .halted_o       (halted),
        .retired_o      (retired)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic fill_rom(input logic [7:0] val);
        for (int i = 0; i < 256; i++) rom[i] = val;
    endtask

    // Walk the program from m_pc until the next instruction that goes to the
    // execute unit, retiring NOPs and branches on the way.
    task automatic model_next_issue(output logic [7:0] ins, output bit ok);
        logic [7:0] op;
        logic [7:0] tgt;
        bit         done;
        ins  = 8'h00;
        ok   = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 600 && !done; n++) begin
            op   = rom[m_pc];
            m_pc = m_pc + 8'd1;
            if (op[7:4] == 4'h0) begin
                m_retired++;
            end else if (op[7:4] == 4'hE || op[7:4] == 4'hF) begin
                tgt = rom[m_pc];
                m_retired++;
                if (op[7:4] == 4'hE || m_carry) begin
                    m_pc = tgt;
                    m_br++;
                end else begin
                    m_pc = m_pc + 8'd1;
                end
            end else begin
                ins  = op;
                ok   = 1'b1;
                done = 1'b1;
            end
        end
    endtask

    // Program region 00..BF is random; branch targets land in C0..FF, which
    // holds only issue opcodes C/D, so every branch reaches an issue soon.
    task automatic build_random_rom();
        int a;
        int r;
        a = 0;
        while (a < 8'hC0) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                rom[a] = 8'(($urandom_range(0, 15)));
                a++;
            end else if (r < 4 && a < 8'hBF) begin
                rom[a]     = {(r == 2) ? 4'hE : 4'hF, 4'($urandom_range(0, 15))};
                rom[a + 1] = 8'($urandom_range(8'hC0, 8'hFF));
                a += 2;
            end else begin
                rom[a] = {4'($urandom_range(1, 13)), 4'($urandom_range(0, 15))};
                a++;
            end
        end
        for (int i = 8'hC0; i < 256; i++) rom[i] = 8'($urandom_range(8'hC0, 8'hDF));
    endtask

    task automatic random_round(input int ncycles);
        logic [7:0] exp_ins;
        bit         ok;
        bit         hs;
        int         obs_br;
        logic       prev_valid, prev_ready, prev_halted;
        logic [7:0] prev_instr, prev_addr;

        build_random_rom();
        instr_ready = 1'b0;
        halt_req    = 1'b0;
        m_carry     = 1'($urandom_range(0, 1));
        carry_in    = m_carry;
        do_reset();
        m_pc = 8'h00; m_retired = 0; m_br = 0; obs_br = 0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_halted = 1'b0;
        prev_instr = 8'h00; prev_addr = 8'h00;

        for (int c = 0; c < ncycles; c++) begin
            if (branch_taken) obs_br++;
            if (prev_valid && !prev_ready) begin
                check_eq("hold_valid", 32'(instr_valid), 32'd1);
                check_eq("hold_instr", 32'(instr), 32'(prev_instr));
            end
            if (halted && prev_halted) check_eq("halt_pc_frozen", 32'(rom_addr), 32'(prev_addr));

            instr_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) halt_req = ~halt_req;
            hs = instr_valid && instr_ready;
            if (hs) begin
                model_next_issue(exp_ins, ok);
                if (!ok) begin
                    checks++;
                    errors++;
                    $display("FAIL model_walk got=no_issue expected=issue");
                end
                check_eq("issue_instr", 32'(instr), 32'(exp_ins));
                check_eq("issue_retired", 32'(retired), 32'(m_retired[15:0]));
                check_eq("branch_count", 32'(obs_br), 32'(m_br));
                m_retired++;
            end
            prev_valid  = instr_valid;
            prev_ready  = instr_ready;
            prev_halted = halted;
            prev_instr  = instr;
            prev_addr   = rom_addr;
            tick();
            if (hs) begin
                m_carry  = 1'($urandom_range(0, 1));
                carry_in = m_carry;
            end
        end
    endtask

    initial begin
        bit   seen;
        reset = 1'b1; carry_in = 1'b0; halt_req = 1'b0; instr_ready = 1'b1;

        // Two back-to-back issue instructions with ready high
        fill_rom(8'h00);
        rom[0] = 8'hCA; rom[1] = 8'hD4;
        do_reset();
        check_eq("rst_instr", 32'(instr), 32'h00);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_branch", 32'(branch_taken), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_retired", 32'(retired), 32'd0);
        check_eq("rst_addr", 32'(rom_addr), 32'h00);
        tick();
        check_eq("t1_valid1", 32'(instr_valid), 32'd1);
        check_eq("t1_instr1", 32'(instr), 32'hCA);
        tick();
        check_eq("t1_valid_drop", 32'(instr_valid), 32'd0);
        check_eq("t1_ret1", 32'(retired), 32'd1);
        tick();
        check_eq("t1_instr2", 32'(instr), 32'hD4);
        check_eq("t1_valid2", 32'(instr_valid), 32'd1);
        check_eq("t1_pc", 32'(rom_addr), 32'h02);
        tick();
        check_eq("t1_ret2", 32'(retired), 32'd2);

        // Stall: ready low for five cycles
        instr_ready = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t2_hold_valid", 32'(instr_valid), 32'd1);
            check_eq("t2_hold_instr", 32'(instr), 32'hCA);
        end
        check_eq("t2_pc", 32'(rom_addr), 32'h01);
        check_eq("t2_ret0", 32'(retired), 32'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("t2_ret1", 32'(retired), 32'd1);
        tick();
        tick();
        check_eq("t2_once", 32'(retired), 32'd1);

        // JMP 10 then INC
        fill_rom(8'h00);
        rom[8'h00] = 8'hE0; rom[8'h01] = 8'h10; rom[8'h10] = 8'hB1;
        instr_ready = 1'b1;
        do_reset();
        tick();
        check_eq("t3_no_branch_yet", 32'(branch_taken), 32'd0);
        tick();
        check_eq("t3_branch", 32'(branch_taken), 32'd1);
        check_eq("t3_addr", 32'(rom_addr), 32'h10);
        check_eq("t3_ret_jmp", 32'(retired), 32'd1);
        tick();
        check_eq("t3_branch_pulse", 32'(branch_taken), 32'd0);
        check_eq("t3_instr", 32'(instr), 32'hB1);
        check_eq("t3_valid", 32'(instr_valid), 32'd1);
        tick();
        check_eq("t3_ret2", 32'(retired), 32'd2);

        // JC not taken / taken
        fill_rom(8'h00);
        rom[8'h00] = 8'hF0; rom[8'h01] = 8'h20;
        for (int cy = 0; cy < 2; cy++) begin
            carry_in = 1'(cy);
            do_reset();
            tick();
            tick();
            check_eq("t4_jc_addr", 32'(rom_addr), (cy != 0) ? 32'h20 : 32'h02);
            check_eq("t4_jc_branch", 32'(branch_taken), 32'(cy));
        end
        carry_in = 1'b0;

        // NOP stream with pc wrap
        fill_rom(8'h00);
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (instr_valid) seen = 1'b1;
            if (i == 2) begin
                check_eq("t5_addr3", 32'(rom_addr), 32'h03);
                check_eq("t5_ret3", 32'(retired), 32'd3);
            end
        end
        check_eq("t5_no_valid", 32'(seen), 32'd0);
        check_eq("t5_wrap_addr", 32'(rom_addr), 32'h00);
        check_eq("t5_wrap_ret", 32'(retired), 32'd256);

        // JMP at FF takes its target from address 00
        fill_rom(8'h00);
        rom[8'hFF] = 8'hE0; rom[8'h00] = 8'h40;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            if (branch_taken) seen = 1'b1;
        end
        check_eq("wrap_jmp_seen", 32'(seen), 32'd1);
        check_eq("wrap_jmp_addr", 32'(rom_addr), 32'h40);
        check_eq("wrap_jmp_ret", 32'(retired), 32'd256);

        // Halt requested during ISSUE
        fill_rom(8'h00);
        rom[0] = 8'hCA; rom[1] = 8'hD4;
        instr_ready = 1'b0;
        do_reset();
        tick();
        halt_req = 1'b1;
        tick();
        tick();
        check_eq("t6_issue_holds", 32'(instr_valid), 32'd1);
        check_eq("t6_not_halted", 32'(halted), 32'd0);
        instr_ready = 1'b1;
        tick();
        check_eq("t6_hs_ret", 32'(retired), 32'd1);
        check_eq("t6_hs_halted", 32'(halted), 32'd0);
        tick();
        check_eq("t6_halted", 32'(halted), 32'd1);
        check_eq("t6_halt_addr", 32'(rom_addr), 32'h01);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t6_frozen_halted", 32'(halted), 32'd1);
            check_eq("t6_frozen_addr", 32'(rom_addr), 32'h01);
        end
        halt_req = 1'b0;
        tick();
        check_eq("t6_unhalt", 32'(halted), 32'd0);
        check_eq("t6_unhalt_addr", 32'(rom_addr), 32'h01);
        tick();
        check_eq("t6_resume_instr", 32'(instr), 32'hD4);
        check_eq("t6_resume_valid", 32'(instr_valid), 32'd1);

        // Reset in the middle of OPERAND
        fill_rom(8'h00);
        rom[1] = 8'hE0; rom[2] = 8'h10;
        do_reset();
        tick();
        tick();
        check_eq("t7_pre_ret", 32'(retired), 32'd1);
        check_eq("t7_pre_addr", 32'(rom_addr), 32'h02);
        reset = 1'b1;
        tick();
        check_eq("t7_rst_addr", 32'(rom_addr), 32'h00);
        check_eq("t7_rst_ret", 32'(retired), 32'd0);
        check_eq("t7_rst_branch", 32'(branch_taken), 32'd0);
        reset = 1'b0;
        tick();
        check_eq("t7_after_addr", 32'(rom_addr), 32'h01);
        check_eq("t7_after_branch", 32'(branch_taken), 32'd0);
        check_eq("t7_after_ret", 32'(retired), 32'd1);

        // Randomised programs against the interpreter
        for (int r = 0; r < 4; r++) random_round(1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
